// File: rtl/maxpool_pkg.sv
// Shared types for the maxpool scheduler: pixel type, FSM states and default map size.
package maxpool_pkg;

   typedef logic signed [7:0] pixel_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLR   = 2'd1,
      S_FEED  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam int DEFAULT_MAP_WIDTH = 28;

endpackage

// File: rtl/maxpool_sched_rr_arbiter.sv
// Round-robin selector: picks the lowest requesting index strictly after last_grant, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   int               cand_i;
   logic [IDX_W-1:0] cand;

   // k runs 1..NUM_REQ so last_grant itself is considered last
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      grant_any    = 1'b0;
      cand_i       = 0;
      cand         = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_i = (int'(last_grant) + k) % NUM_REQ;
         cand   = IDX_W'(cand_i);
         if (!grant_any && req[cand]) begin
            grant_any          = 1'b1;
            grant_idx          = cand;
            grant_onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/maxpool_sched.sv
// Time-shares one maxpool engine between NUM_REQ channel requesters, one full frame per grant.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no frame in flight; arbitrate among valid requesters
// S_CLR   | one-cycle engine clear, frame counters zeroed
// S_FEED  | accept MAP_WIDTH^2 pixels from the granted channel
// S_DRAIN | wait for engine all_done (bounded by DRAIN_TIMEOUT)
module maxpool_sched
   import maxpool_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int MAP_WIDTH     = DEFAULT_MAP_WIDTH,
   parameter int DRAIN_TIMEOUT = 500,
   parameter int CHAN_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_pixel,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 eng_clr,
   output logic                 eng_valid_in,
   output pixel_t               eng_pixel_in,
   input  logic                 eng_valid_out,
   input  pixel_t               eng_pixel_out,
   input  logic                 eng_all_done,
   output logic                 out_valid,
   output pixel_t               out_pixel,
   output logic [CHAN_W-1:0]    out_chan,
   output logic                 out_last,
   output logic                 busy,
   output logic                 err_timeout,
   output logic                 err_count
);

   localparam int FRAME_PIX = MAP_WIDTH * MAP_WIDTH;
   localparam int OUT_PIX   = (MAP_WIDTH / 2) * (MAP_WIDTH / 2);
   localparam int IN_CNT_W  = $clog2(FRAME_PIX) + 1;
   localparam int OUT_CNT_W = $clog2(OUT_PIX) + 1;
   localparam int TMR_W     = $clog2(DRAIN_TIMEOUT) + 1;

   localparam logic [IN_CNT_W-1:0]  IN_LAST   = IN_CNT_W'(FRAME_PIX - 1);
   localparam logic [OUT_CNT_W-1:0] OUT_TOTAL = OUT_CNT_W'(OUT_PIX);
   localparam logic [OUT_CNT_W-1:0] OUT_LAST  = OUT_CNT_W'(OUT_PIX - 1);
   localparam logic [TMR_W-1:0]     TMR_LOAD  = TMR_W'(DRAIN_TIMEOUT - 1);

   state_t                state, state_nxt;
   logic [CHAN_W-1:0]     grant, grant_nxt;
   logic [NUM_REQ-1:0]    grant_oh, grant_oh_nxt;
   logic [CHAN_W-1:0]     last_grant, last_grant_nxt;
   logic [IN_CNT_W-1:0]   in_cnt, in_cnt_nxt;
   logic [OUT_CNT_W-1:0]  out_cnt, out_cnt_nxt;
   logic [OUT_CNT_W-1:0]  out_cnt_total;
   logic [TMR_W-1:0]      tmr, tmr_nxt;
   logic                  err_timeout_nxt, err_count_nxt;

   logic [NUM_REQ-1:0]    arb_onehot;
   logic [CHAN_W-1:0]     arb_idx;
   logic                  arb_any;

   pixel_t                pix_arr [NUM_REQ];
   pixel_t                sel_pixel;
   logic                  feeding, handshake, eng_out_act;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (CHAN_W)
   ) u_arb (
      .req          (req_valid),
      .last_grant   (last_grant),
      .grant_onehot (arb_onehot),
      .grant_idx    (arb_idx),
      .grant_any    (arb_any)
   );

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         pix_arr[i] = req_pixel[i*8 +: 8];
      end
   end

   assign sel_pixel   = pix_arr[grant];
   assign feeding     = (state == S_FEED);
   assign req_ready   = feeding ? grant_oh : '0;
   assign handshake   = feeding && req_valid[grant];
   assign eng_clr     = (state == S_CLR);
   assign busy        = (state != S_IDLE);

   // Engine results are only meaningful while this scheduler owns a frame
   assign eng_out_act = eng_valid_out && ((state == S_FEED) || (state == S_DRAIN));
   assign out_valid   = eng_out_act;
   assign out_pixel   = eng_out_act ? eng_pixel_out : '0;
   assign out_chan    = eng_out_act ? grant : '0;
   assign out_last    = eng_out_act && (out_cnt == OUT_LAST);

   assign out_cnt_total = out_cnt + OUT_CNT_W'(eng_out_act);

   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      grant_oh_nxt    = grant_oh;
      last_grant_nxt  = last_grant;
      in_cnt_nxt      = in_cnt;
      out_cnt_nxt     = eng_out_act ? out_cnt_total : out_cnt;
      tmr_nxt         = tmr;
      err_timeout_nxt = 1'b0;
      err_count_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (arb_any) begin
               grant_nxt    = arb_idx;
               grant_oh_nxt = arb_onehot;
               state_nxt    = S_CLR;
            end
         end
         S_CLR: begin
            in_cnt_nxt  = '0;
            out_cnt_nxt = '0;
            state_nxt   = S_FEED;
         end
         S_FEED: begin
            if (handshake) begin
               in_cnt_nxt = in_cnt + IN_CNT_W'(1);
               if (in_cnt == IN_LAST) begin
                  tmr_nxt   = TMR_LOAD;
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (eng_all_done) begin
               last_grant_nxt = grant;
               err_count_nxt  = (out_cnt_total != OUT_TOTAL);
               state_nxt      = S_IDLE;
            end else if (tmr == '0) begin
               last_grant_nxt  = grant;
               err_timeout_nxt = 1'b1;
               state_nxt       = S_IDLE;
            end else begin
               tmr_nxt = tmr - TMR_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         grant        <= '0;
         grant_oh     <= '0;
         last_grant   <= CHAN_W'(NUM_REQ - 1);
         in_cnt       <= '0;
         out_cnt      <= '0;
         tmr          <= '0;
         err_timeout  <= 1'b0;
         err_count    <= 1'b0;
         eng_valid_in <= 1'b0;
         eng_pixel_in <= '0;
      end else begin
         state        <= state_nxt;
         grant        <= grant_nxt;
         grant_oh     <= grant_oh_nxt;
         last_grant   <= last_grant_nxt;
         in_cnt       <= in_cnt_nxt;
         out_cnt      <= out_cnt_nxt;
         tmr          <= tmr_nxt;
         err_timeout  <= err_timeout_nxt;
         err_count    <= err_count_nxt;
         eng_valid_in <= handshake;
         if (handshake) begin
            eng_pixel_in <= sel_pixel;
         end
      end
   end

endmodule

// File: tb/tb_maxpool_sched.sv
// Scoreboard bench for maxpool_sched with a behavioural 2x2 maxpool engine stand-in.
module tb_maxpool_sched;

   localparam int NR = 4;
   localparam int MW = 28;
   localparam int FP = MW * MW;
   localparam int HW = MW / 2;
   localparam int OP = HW * HW;
   localparam int TO = 500;

   logic                clk = 1'b0;
   logic                rst;
   logic [NR-1:0]       req_valid;
   logic [NR*8-1:0]     req_pixel;
   logic [NR-1:0]       req_ready;
   logic                eng_clr;
   logic                eng_valid_in;
   logic signed [7:0]   eng_pixel_in;
   logic                eng_valid_out = 1'b0;
   logic signed [7:0]   eng_pixel_out = '0;
   logic                eng_all_done  = 1'b0;
   logic                out_valid;
   logic signed [7:0]   out_pixel;
   logic [1:0]          out_chan;
   logic                out_last;
   logic                busy;
   logic                err_timeout;
   logic                err_count;

   always #5 clk = ~clk;

   maxpool_sched #(
      .NUM_REQ       (NR),
      .MAP_WIDTH     (MW),
      .DRAIN_TIMEOUT (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_pixel     (req_pixel),
      .req_ready     (req_ready),
      .eng_clr       (eng_clr),
      .eng_valid_in  (eng_valid_in),
      .eng_pixel_in  (eng_pixel_in),
      .eng_valid_out (eng_valid_out),
      .eng_pixel_out (eng_pixel_out),
      .eng_all_done  (eng_all_done),
      .out_valid     (out_valid),
      .out_pixel     (out_pixel),
      .out_chan      (out_chan),
      .out_last      (out_last),
      .busy          (busy),
      .err_timeout   (err_timeout),
      .err_count     (err_count)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [7:0] max2(input logic signed [7:0] a, input logic signed [7:0] b);
      return (a > b) ? a : b;
   endfunction

   typedef struct {
      logic signed [7:0] pix;
      logic [1:0]        chan;
      logic              last;
   } exp_t;
   exp_t sb[$];

   logic signed [7:0] src_frame [NR][FP];
   logic signed [7:0] saved [FP];
   int  src_idx [NR];
   int  frames_left [NR];
   bit  gap [NR];
   int  last_done_cyc = 0;

   // Fill a source frame and push its golden pooled results in output order
   task automatic load_frame(input int ch, input bit reuse);
      logic signed [7:0] m;
      exp_t e;
      for (int k = 0; k < FP; k++) begin
         src_frame[ch][k] = reuse ? saved[k] : 8'($urandom);
      end
      for (int r = 0; r < HW; r++) begin
         for (int c = 0; c < HW; c++) begin
            m = max2(max2(src_frame[ch][(2*r)*MW + 2*c],   src_frame[ch][(2*r)*MW + 2*c + 1]),
                     max2(src_frame[ch][(2*r+1)*MW + 2*c], src_frame[ch][(2*r+1)*MW + 2*c + 1]));
            e.pix  = m;
            e.chan = 2'(ch);
            e.last = (r * HW + c == OP - 1);
            sb.push_back(e);
         end
      end
   endtask

   task automatic drive();
      for (int ch = 0; ch < NR; ch++) begin
         req_valid[ch] = (frames_left[ch] > 0) && (!gap[ch] || ($urandom_range(0, 1) == 1));
         req_pixel[ch*8 +: 8] = src_frame[ch][src_idx[ch]];
      end
   endtask

   task automatic step();
      logic [NR-1:0] hs;
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int ch = 0; ch < NR; ch++) begin
         if (hs[ch]) begin
            src_idx[ch]++;
            if (src_idx[ch] == FP) begin
               src_idx[ch] = 0;
               frames_left[ch]--;
               last_done_cyc = cyc;
               if (frames_left[ch] > 0) load_frame(ch, 1'b0);
            end
         end
      end
      drive();
   endtask

   function automatic bit sources_done();
      for (int ch = 0; ch < NR; ch++) if (frames_left[ch] != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_idle(input int budget, input string tag);
      int  n = 0;
      bit  done = 1'b0;
      while (!done && n < budget) begin
         step();
         n++;
         done = sources_done() && (sb.size() == 0) && !busy;
      end
      chk({tag, "_complete"}, 32'(done), 32'd1);
      repeat (2) step();
   endtask

   // Behavioural engine: emits the 2x2 max when the bottom-right pixel of a window arrives
   logic signed [7:0] eb [FP];
   int  e_in = 0, e_out = 0;
   bit  e_done_pend = 1'b0;
   bit  no_done = 1'b0;
   always @(posedge clk) begin
      eng_valid_out <= 1'b0;
      eng_all_done  <= 1'b0;
      if (rst || eng_clr) begin
         e_in = 0;
         e_out = 0;
         e_done_pend = 1'b0;
      end else begin
         if (e_done_pend) begin
            eng_all_done <= !no_done;
            e_done_pend = 1'b0;
         end
         if (eng_valid_in && e_in < FP) begin
            eb[e_in] = eng_pixel_in;
            if (((e_in / MW) % 2 == 1) && ((e_in % MW) % 2 == 1)) begin
               eng_valid_out <= 1'b1;
               eng_pixel_out <= max2(max2(eb[e_in - MW - 1], eb[e_in - MW]), max2(eb[e_in - 1], eb[e_in]));
               e_out++;
               if (e_out == OP) e_done_pend = 1'b1;
            end
            e_in++;
         end
      end
   end

   int to_pulses = 0, cnt_pulses = 0, to_cyc = -1, clr_pulses = 0, last_pulses = 0, bad_ready = 0;
   int out_seen [NR];
   bit watch_ready = 1'b0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
         if (err_timeout) begin to_pulses++; to_cyc = cyc; end
         if (err_count) cnt_pulses++;
         if (eng_clr) clr_pulses++;
         if (watch_ready && ((req_ready & 4'b1101) != 4'b0000)) bad_ready++;
         if (out_valid) begin
            out_seen[out_chan]++;
            if (out_last) last_pulses++;
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               chk("out_pixel", 32'(out_pixel), 32'(mon_e.pix));
               chk("out_chan", 32'(out_chan), 32'(mon_e.chan));
               chk("out_last", 32'(out_last), 32'(mon_e.last));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      req_valid = '1;
      req_pixel = '0;
      for (int ch = 0; ch < NR; ch++) begin
         src_idx[ch] = 0; frames_left[ch] = 0; gap[ch] = 1'b0; out_seen[ch] = 0;
      end
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({req_ready, eng_clr, eng_valid_in, eng_pixel_in, out_valid, out_pixel,
                                out_chan, out_last, busy, err_timeout, err_count}), 32'd0);
      req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;

      // four channels, two frames each, continuous valid
      for (int ch = 0; ch < NR; ch++) begin
         frames_left[ch] = 2;
         load_frame(ch, 1'b0);
      end
      drive();
      run_idle(12000, "four_chan");
      for (int ch = 0; ch < NR; ch++) chk("four_chan_count", 32'(out_seen[ch]), 32'(2 * OP));
      chk("four_chan_last", 32'(last_pulses), 32'd8);

      // single channel 2, random frame
      for (int ch = 0; ch < NR; ch++) out_seen[ch] = 0;
      last_pulses = 0;
      frames_left[2] = 1;
      load_frame(2, 1'b0);
      saved = src_frame[2];
      drive();
      run_idle(2000, "chan2");
      chk("chan2_count", 32'(out_seen[2]), 32'(OP));
      chk("chan2_last", 32'(last_pulses), 32'd1);

      // channel 1 with random gaps, same data as channel 2 run
      out_seen[1] = 0;
      watch_ready = 1'b1;
      gap[1] = 1'b1;
      frames_left[1] = 1;
      load_frame(1, 1'b1);
      drive();
      run_idle(6000, "chan1_gaps");
      watch_ready = 1'b0;
      gap[1] = 1'b0;
      chk("chan1_other_ready", 32'(bad_ready), 32'd0);
      chk("chan1_count", 32'(out_seen[1]), 32'(OP));
      chk("no_err_count", 32'(cnt_pulses), 32'd0);
      chk("no_err_timeout", 32'(to_pulses), 32'd0);

      // engine never signals all_done
      no_done = 1'b1;
      frames_left[0] = 1;
      load_frame(0, 1'b0);
      drive();
      run_idle(3000, "timeout");
      no_done = 1'b0;
      chk("timeout_pulses", 32'(to_pulses), 32'd1);
      chk("timeout_delay", 32'(to_cyc - last_done_cyc), 32'(TO));
      chk("timeout_idle", 32'(busy), 32'd0);
      out_seen[3] = 0;
      frames_left[3] = 1;
      load_frame(3, 1'b0);
      drive();
      run_idle(2000, "after_timeout");
      chk("after_timeout_count", 32'(out_seen[3]), 32'(OP));
      chk("after_timeout_pulses", 32'(to_pulses), 32'd1);

      // reset at pixel 300 of a frame
      frames_left[2] = 1;
      load_frame(2, 1'b0);
      drive();
      for (int n = 0; n < 1000 && src_idx[2] < 300; n++) step();
      chk("pre_reset_progress", 32'(src_idx[2]), 32'd300);
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", 32'({req_ready, eng_clr, eng_valid_in, eng_pixel_in, out_valid, out_pixel,
                                      out_chan, out_last, busy, err_timeout, err_count}), 32'd0);
      sb.delete();
      for (int ch = 0; ch < NR; ch++) begin src_idx[ch] = 0; frames_left[ch] = 0; end
      drive();
      repeat (3) @(posedge clk);
      #1;
      frames_left[0] = 1; load_frame(0, 1'b0);
      frames_left[2] = 1; load_frame(2, 1'b0);
      clr_pulses = 0;
      to_pulses = 0;
      last_pulses = 0;
      drive();
      rst = 1'b0;
      for (int n = 0; n < 20 && req_ready == '0; n++) step();
      chk("post_reset_first_grant", 32'(req_ready), 32'd1);
      chk("post_reset_clr", 32'(clr_pulses), 32'd1);
      run_idle(4000, "post_reset");
      chk("post_reset_last", 32'(last_pulses), 32'd2);
      chk("post_reset_err", 32'(to_pulses + cnt_pulses), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/maxpool_sched.md
MAXPOOL_SCHED -- requirements
Module: maxpool_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of channel requesters sharing one maxpool_engine.
REQ-002 Parameter MAP_WIDTH, default 28: input map side; frame = MAP_WIDTH*MAP_WIDTH pixels, output = (MAP_WIDTH/2)^2 pixels.
REQ-003 Parameter DRAIN_TIMEOUT, default 500: maximum cycles in DRAIN waiting for eng_all_done.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-channel pixel valid.
REQ-007 req_pixel  input  NUM_REQ*8  per-channel signed 8-bit pixel; channel i at bits [8i+7:8i].
REQ-008 req_ready  output  NUM_REQ  per-channel accept; at most one bit high.
REQ-009 eng_clr  output  1  one-cycle clear pulse to the engine's rst.
REQ-010 eng_valid_in / eng_pixel_in  output  1 / 8  stream to the engine.
REQ-011 eng_valid_out / eng_pixel_out / eng_all_done  input  1 / 8 / 1  engine results.
REQ-012 out_valid / out_pixel  output  1 / 8  pooled result stream.
REQ-013 out_chan  output  $clog2(NUM_REQ)  channel of the current out_pixel.
REQ-014 out_last  output  1  marks the final pooled pixel of a frame.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 err_timeout / err_count  output  1 / 1  one-cycle error pulses.

Function
REQ-017 FSM states: IDLE, CLR, FEED, DRAIN.
REQ-018 IDLE: when any req_valid is high, grant the lowest index strictly after last_grant (wrapping), latch grant, go to CLR.
REQ-019 CLR: eng_clr=1 for exactly one cycle; zero input/output counters; go to FEED.
REQ-020 FEED: req_ready[grant]=1 and all other bits 0; a handshake is req_valid[grant]&req_ready[grant].
REQ-021 Each handshake drives eng_valid_in=1 and eng_pixel_in=pixel on the next cycle (1-cycle registered latency); eng_valid_in=0 in every other cycle; requester gaps are passed through as bubbles.
REQ-022 After the MAP_WIDTH^2-th handshake, req_ready drops in the same cycle the FSM moves to DRAIN; no further pixels are accepted for that frame.
REQ-023 In FEED and DRAIN, every eng_valid_out cycle produces out_valid=1 with out_pixel=eng_pixel_out and out_chan=grant in the same cycle (combinational pass-through), and increments the output counter.
REQ-024 out_last=1 when out_valid coincides with output count (MAP_WIDTH/2)^2-1 (0-based).
REQ-025 DRAIN: on eng_all_done, set last_grant=grant and go to IDLE; if the output count including any same-cycle eng_valid_out differs from (MAP_WIDTH/2)^2, pulse err_count.
REQ-026 DRAIN timeout: after DRAIN_TIMEOUT cycles without eng_all_done, pulse err_timeout, update last_grant and go to IDLE; the next frame's CLR clears the engine.
REQ-027 eng_all_done and eng_valid_out are ignored in IDLE and CLR.
REQ-028 With a single requester active, back-to-back frames are served with two idle cycles between frames (IDLE, CLR).
REQ-029 Counter widths are $clog2 of the count + 1; no wrap occurs within a frame.

Reset
REQ-030 On rst: state=IDLE; last_grant=NUM_REQ-1, so requester 0 is served first; counters=0; all outputs 0 (req_ready, eng_clr, eng_valid_in, eng_pixel_in, out_*, busy, err_*).
REQ-031 Reset mid-frame abandons the frame with no out_last or error pulse; the first post-reset frame begins with a CLR pulse.

Structure
REQ-032 Shared package maxpool_pkg holds the pixel_t (signed 8-bit) typedef, the FSM state enum and the default MAP_WIDTH.
REQ-033 One sub-module rr_arbiter (NUM_REQ requests, last_grant in, one-hot and index grant out) implements the round-robin selection.

Verification
REQ-034 Bench instantiates maxpool_sched with maxpool_engine at MAP_WIDTH=28 and a golden 2x2 max model.
REQ-035 Single channel 2, random frame, valid always high -> 196 out_valid, all with out_chan=2, out_last on the 196th, values match golden, no errors.
REQ-036 All 4 channels valid continuously, 2 frames each -> grant order 0,1,2,3,0,1,2,3; each frame yields 196 correct pixels.
REQ-037 Channel 1 with 50% random valid gaps -> results identical to the gap-free run; req_ready[0,2,3] never high.
REQ-038 Engine model that never asserts all_done -> err_timeout pulses exactly 500 cycles after DRAIN entry; FSM returns to IDLE; the next frame succeeds.
REQ-039 Assert rst at pixel 300 of a frame -> all outputs 0 asynchronously; after release, requester 0 is served first with a fresh eng_clr pulse.
